uart_rx_stream: RTL and testbench
=================================

Name: uart_rx_stream

Overview:
- 8N1 UART receiver with 16x oversampling.
- Recovers bytes from the board RsRx pin and presents them on a valid/ready stream port.
- Counterpart to the existing UART transmit path; feeds command and echo logic in the top-level system.
- Flags framing errors and overruns so downstream logic never consumes a corrupt or lost byte silently.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits per second.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 8.
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  DATA_BITS  received byte; stable while valid is high.
- valid  out  1  byte available.
- ready  in  1  consumer accepts the byte when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte was dropped because valid was still held.
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 when the feature is compiled out.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-low (rst_n).
- Reset values:
  - data_out = 0; valid, frame_err, overrun, parity_err = 0.
  - State = IDLE.
  - Both synchronizer flops = 1.
  - Tick and bit counters = 0.
- Input path: rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (651 at the defaults).
  - Emits a one-cycle tick every DIV clocks.
  - Its counter is cleared when a start edge is detected, so sampling aligns to the frame.
- States: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: a falling edge on rx_s (previous 1, current 0) clears the counters and moves to START.
  - START: after OVERSAMPLE/2 ticks, sample rx_s. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no flags raised.
  - DATA: sample every OVERSAMPLE ticks (the bit centre) and shift in LSB first. After DATA_BITS samples, go to STOP, or to PARITY if the feature is enabled.
  - STOP: sample after OVERSAMPLE ticks.
    - If 1: commit the byte and return to IDLE.
    - If 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This covers a break condition.
- Commit:
  - Happens in the cycle of the stop-bit sample. valid and data_out update on the next clock edge, so latency is 1 clk from stop-bit centre to valid.
  - If valid = 0, or valid && ready in the same cycle: load data_out and set valid = 1. No overrun.
  - If valid = 1 && ready = 0: keep the old data_out, drop the new byte, pulse overrun.
- Handshake:
  - valid && ready with no commit in that cycle: valid goes to 0 next cycle.
  - valid never deasserts without ready, except on reset.
  - data_out does not change while valid = 1.
- Reset mid-frame: the partial byte is lost, state returns to IDLE, and no flags pulse.
- Pulses: frame_err, overrun and parity_err are each exactly one clock wide and mutually independent.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits and is sampled in the PARITY state.
  - On mismatch, parity_err pulses in the stop-sample cycle and the byte is discarded. The stop bit is still checked and the normal state flow continues.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - The state enum (rx_state_t).
  - A function calc_div(CLK_FREQ, BAUD, OVERSAMPLE) that returns DIV.
  - The constant IDLE_LEVEL = 1.
- Sub-module uart_baud_tick:
  - Parameterised by DIV.
  - Inputs: clk, rst_n, clear. Output: tick.
  - Reused by the transmitter.

Test Plan:
- Bench parameters: CLK_FREQ = 1_600_000, BAUD = 100_000, so DIV = 1 and one bit lasts 16 clocks.
- Test 1: with ready held 1, send 0xA5 as an 8N1 frame -> valid pulses 1 cycle after the stop centre, data_out = 0xA5, no flags.
- Test 2: with ready = 0, send 0x3C then 0x7E -> first byte is held at 0x3C, overrun pulses once, and after ready = 1 the consumer reads 0x3C and valid drops.
- Test 3: send 0x55 with the stop bit forced low, then hold rx low for 40 clocks -> frame_err pulses once, valid stays 0, and the next good frame 0x12 is received correctly.
- Test 4: apply a rx low glitch of 5 clocks -> no state advance beyond START, no flags, and a following 0xFF frame is received.
- Test 5: assert rst_n = 0 during the 4th data bit of 0x81, then send 0x81 again -> only one valid, with data_out = 0x81.
- Test 6 (UART_RX_PARITY_EN): send 0x07 with parity bit 0 (wrong; correct is 1) -> parity_err pulses and there is no valid; the same byte with parity 1 -> valid with data_out = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit paths.
//   rx_state_t : receiver FSM states
//   IDLE_LEVEL : line level while idle (and reset value of the rx synchronizer)
//   calc_div   : clocks per oversample tick
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Truncated divider; clamped to 1 so a too-fast baud still yields a working tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned div;
        div = clk_freq / (baud * oversample);
        return (div == 0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator, shared by the UART receiver and transmitter.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clear : restart the divider (aligns ticks to a frame start); suppresses tick
//   tick  : one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver (16x oversampling) with a valid/ready output stream.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   rx         : asynchronous serial input, idles high
//   data_out   : received byte, held while valid is high
//   valid      : byte available
//   ready      : consumer accepts the byte when valid && ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, a new byte was dropped because valid was still pending
//   parity_err : one-cycle pulse, parity mismatch (constant 0 without UART_RX_PARITY_EN)
module uart_rx_stream #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    rx_state_t state_q, state_d;

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 parity_err_q, parity_err_d;

    logic tick, start_edge, half_hit, full_hit, commit;

    // Input synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_s_q    <= IDLE_LEVEL;
            rx_prev_q <= IDLE_LEVEL;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s_q;

    uart_baud_tick #(
        .DIV (Div)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_edge),
        .tick  (tick)
    );

    assign half_hit = tick && (tick_cnt_q == HalfLast);
    assign full_hit = tick && (tick_cnt_q == FullLast);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_edge) state_d = StStart;
            StStart:    if (half_hit) state_d = rx_s_q ? StIdle : StData;
            StData:     if (full_hit && (bit_cnt_q == BitLast)) begin
                            state_d = ParityEn ? StParity : StStop;
                        end
            StParity:   if (full_hit) state_d = StStop;
            StStop:     if (full_hit) state_d = rx_s_q ? StIdle : StWaitHigh;
            StWaitHigh: if (rx_s_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath and output next-state logic
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        commit       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                par_bad_d  = 1'b0;
            end
            StStart: begin
                if (half_hit) tick_cnt_d = '0;
                else if (tick) tick_cnt_d = tick_cnt_q + TickW'(1);
            end
            StData: begin
                if (full_hit) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + BitW'(1);
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};  // LSB first
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                end
            end
            StParity: begin
                if (full_hit) begin
                    tick_cnt_d = '0;
                    par_bad_d  = rx_s_q != (^shift_q);
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                end
            end
            StStop: begin
                if (full_hit) begin
                    tick_cnt_d   = '0;
                    parity_err_d = par_bad_q;
                    frame_err_d  = !rx_s_q;
                    commit       = rx_s_q && !par_bad_q;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + TickW'(1);
                end
            end
            StWaitHigh: ;
            default: ;
        endcase
    end

    // Output stream: a pending byte is never overwritten; a new one is dropped instead.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && ready) valid_d = 1'b0;
        if (commit) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign parity_err = ParityEn ? parity_err_q : 1'b0;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks per bit (DIV = 1).
module tb_uart_rx_stream;

`ifdef UART_RX_PARITY_EN
    localparam bit ParityEn = 1'b1;
    localparam int Lat = 171;  // start drive -> valid visible, with parity bit
`else
    localparam bit ParityEn = 1'b0;
    localparam int Lat = 155;  // 2 sync + 8 start + 9*16 to stop centre + 1 commit
`endif

    logic       clk = 1'b0;
    logic       rst_n, rx, ready;
    logic [7:0] data_out;
    logic       valid, frame_err, overrun, parity_err;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, start_cyc = 0;
    int fe_cnt, ov_cnt, pe_cnt, rise_cnt, rise_cyc, acc_cnt;
    logic [7:0] acc_data;
    logic valid_prev = 1'b0;

    uart_rx_stream #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder; inputs change just after posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (parity_err) pe_cnt++;
        if (valid && !valid_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        valid_prev = valid;
        if (valid && ready) begin
            acc_cnt++;
            acc_data = data_out;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; rise_cnt = 0; rise_cyc = 0; acc_cnt = 0;
        acc_data = 8'h00;
    endtask

    // Leaves rx at the stop level; par_flip inverts the even-parity bit when parity is built in.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        start_cyc = cyc;
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(16);
        end
        if (ParityEn) begin
            rx = (^d) ^ par_flip;
            step(16);
        end
        rx = stop;
        step(16);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
        step(3);
        n_chk++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        n_chk++; if ({frame_err, overrun, parity_err} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err});
        else n_pass++;
        rst_n = 1'b1;
        step(5);
        clear_counts();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        clear_counts();
        drive_frame(8'hA5, 1'b1, 1'b0);
        step(20);
        n_chk++; if (rise_cnt !== 1) $display("FAIL basic_valid_count: got %0d want 1", rise_cnt); else n_pass++;
        n_chk++; if (rise_cyc - start_cyc !== Lat)
            $display("FAIL basic_latency: got %0d want %0d", rise_cyc - start_cyc, Lat);
        else n_pass++;
        n_chk++; if (acc_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", acc_data); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", valid); else n_pass++;
        n_chk++; if (fe_cnt + ov_cnt + pe_cnt !== 0)
            $display("FAIL basic_flags: got %0d pulses want 0", fe_cnt + ov_cnt + pe_cnt);
        else n_pass++;
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        clear_counts();
        drive_frame(8'h3C, 1'b1, 1'b0);
        drive_frame(8'h7E, 1'b1, 1'b0);
        step(20);
        n_chk++; if (valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", valid); else n_pass++;
        n_chk++; if (data_out !== 8'h3C) $display("FAIL ovr_data_held: got %h want 3c", data_out); else n_pass++;
        n_chk++; if (ov_cnt !== 1) $display("FAIL ovr_pulses: got %0d want 1", ov_cnt); else n_pass++;
        n_chk++; if (rise_cnt !== 1) $display("FAIL ovr_valid_count: got %0d want 1", rise_cnt); else n_pass++;
        ready = 1'b1;
        step(1);
        n_chk++; if (acc_cnt !== 1) $display("FAIL ovr_accepts: got %0d want 1", acc_cnt); else n_pass++;
        n_chk++; if (acc_data !== 8'h3C) $display("FAIL ovr_read: got %h want 3c", acc_data); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL ovr_valid_drop: got %b want 0", valid); else n_pass++;
    endtask

    task automatic test_frame_err();
        clear_counts();
        drive_frame(8'h55, 1'b0, 1'b0);
        step(40);
        n_chk++; if (valid !== 1'b0) $display("FAIL ferr_valid_low: got %b want 0", valid); else n_pass++;
        rx = 1'b1;
        step(20);
        n_chk++; if (fe_cnt !== 1) $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); else n_pass++;
        n_chk++; if (rise_cnt !== 0) $display("FAIL ferr_no_valid: got %0d want 0", rise_cnt); else n_pass++;
        drive_frame(8'h12, 1'b1, 1'b0);
        step(20);
        n_chk++; if (rise_cnt !== 1) $display("FAIL ferr_next_count: got %0d want 1", rise_cnt); else n_pass++;
        n_chk++; if (acc_data !== 8'h12) $display("FAIL ferr_next_data: got %h want 12", acc_data); else n_pass++;
        n_chk++; if (fe_cnt !== 1) $display("FAIL ferr_total: got %0d want 1", fe_cnt); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_counts();
        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(30);
        n_chk++; if (rise_cnt + fe_cnt + ov_cnt + pe_cnt !== 0)
            $display("FAIL glitch_quiet: got %0d events want 0", rise_cnt + fe_cnt + ov_cnt + pe_cnt);
        else n_pass++;
        drive_frame(8'hFF, 1'b1, 1'b0);
        step(20);
        n_chk++; if (rise_cnt !== 1) $display("FAIL glitch_next_count: got %0d want 1", rise_cnt); else n_pass++;
        n_chk++; if (acc_data !== 8'hFF) $display("FAIL glitch_next_data: got %h want ff", acc_data); else n_pass++;
        n_chk++; if (rise_cyc - start_cyc !== Lat)
            $display("FAIL glitch_latency: got %0d want %0d", rise_cyc - start_cyc, Lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h81;
        clear_counts();
        rx = 1'b0;
        step(16);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            step(16);
        end
        rx = d[3];
        step(8);
        rst_n = 1'b0;
        rx = 1'b1;
        step(2);
        rst_n = 1'b1;
        n_chk++; if (data_out !== 8'h00) $display("FAIL midrst_data: got %h want 00", data_out); else n_pass++;
        step(20);
        drive_frame(8'h81, 1'b1, 1'b0);
        step(20);
        n_chk++; if (rise_cnt !== 1) $display("FAIL midrst_count: got %0d want 1", rise_cnt); else n_pass++;
        n_chk++; if (acc_data !== 8'h81) $display("FAIL midrst_data_rx: got %h want 81", acc_data); else n_pass++;
        n_chk++; if (fe_cnt + ov_cnt + pe_cnt !== 0)
            $display("FAIL midrst_flags: got %0d pulses want 0", fe_cnt + ov_cnt + pe_cnt);
        else n_pass++;
    endtask

    task automatic test_parity();
        clear_counts();
        drive_frame(8'h07, 1'b1, 1'b1);
        step(20);
        n_chk++; if (pe_cnt !== 1) $display("FAIL par_bad_pulses: got %0d want 1", pe_cnt); else n_pass++;
        n_chk++; if (rise_cnt !== 0) $display("FAIL par_bad_no_valid: got %0d want 0", rise_cnt); else n_pass++;
        drive_frame(8'h07, 1'b1, 1'b0);
        step(20);
        n_chk++; if (rise_cnt !== 1) $display("FAIL par_good_count: got %0d want 1", rise_cnt); else n_pass++;
        n_chk++; if (acc_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", acc_data); else n_pass++;
        n_chk++; if (pe_cnt !== 1) $display("FAIL par_total: got %0d want 1", pe_cnt); else n_pass++;
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        if (ParityEn) test_parity();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
